// File: rtl/fifo_rd_packer_pkg.sv
// Shared types and constants for the FIFO read packer.
package fifo_rd_packer_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_PACK_RATIO = 4;

  // Counters must reach PACK_RATIO itself, hence one extra bit.
  function automatic int unsigned cnt_width(input int unsigned ratio);
    return $clog2(ratio) + 1;
  endfunction

endpackage

// File: rtl/pack_out_slot.sv
// Valid/ready output holding register; a load wins over a same-edge pop.
// Optional lane-valid mask when PACKER_FLUSH_EN is defined.
module pack_out_slot #(
  parameter int unsigned WIDTH = 32
`ifdef PACKER_FLUSH_EN
  , parameter int unsigned KEEP_W = 4
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_data,
`ifdef PACKER_FLUSH_EN
  input  logic [KEEP_W-1:0] load_keep,
  output logic [KEEP_W-1:0] m_keep,
`endif
  input  logic              m_ready,
  output logic              m_valid,
  output logic [WIDTH-1:0]  m_data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
`ifdef PACKER_FLUSH_EN
      m_keep  <= '0;
`endif
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= load_data;
`ifdef PACKER_FLUSH_EN
      m_keep  <= load_keep;
`endif
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains a narrow FIFO and packs PACK_RATIO words into one valid/ready word.
// PACKER_FLUSH_EN adds flush/m_keep for emitting partial words.
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned PACK_RATIO = DEF_PACK_RATIO
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             fifo_empty,
  input  logic [DATA_WIDTH-1:0]            fifo_data,
  output logic                             fifo_rd_en,
`ifdef PACKER_FLUSH_EN
  input  logic                             flush,
  output logic [PACK_RATIO-1:0]            m_keep,
`endif
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data
);

  localparam int unsigned CW = cnt_width(PACK_RATIO);
  localparam logic [CW-1:0] FULL = CW'(PACK_RATIO);
  localparam logic [CW-1:0] LAST = CW'(PACK_RATIO - 1);

  state_t                               state;
  logic [CW-1:0]                        rd_issued;
  logic [CW-1:0]                        lanes_cap;
  logic                                 in_flight;
  logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] acc;

  logic                                 slot_free;
  logic                                 flush_go;
  logic                                 load;
  logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] acc_cap;
  logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] load_data;
  logic [PACK_RATIO-1:0]                load_keep;

  // Read request, capture merge and slot-load decode.
  always_comb begin
    slot_free = !m_valid || m_ready;
    acc_cap   = acc;
    if (in_flight) begin
      for (int unsigned i = 0; i < PACK_RATIO; i++) begin
        if (CW'(i) == lanes_cap) acc_cap[i] = fifo_data;
      end
    end

`ifdef PACKER_FLUSH_EN
    flush_go = (state == FILL) && flush && (lanes_cap != '0) && !in_flight && slot_free;
`else
    flush_go = 1'b0;
`endif

    fifo_rd_en = rst_n && !fifo_empty && (rd_issued < FULL) && (state != HOLD) && !flush_go;

    load = flush_go
        || ((state == DRAIN) && in_flight && slot_free)
        || ((state == HOLD) && slot_free);

    load_data = acc_cap;
    load_keep = '1;
    if (flush_go) begin
      for (int unsigned i = 0; i < PACK_RATIO; i++) begin
        if (CW'(i) >= lanes_cap) begin
          load_data[i] = '0;
          load_keep[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      rd_issued <= '0;
      lanes_cap <= '0;
      in_flight <= 1'b0;
      acc       <= '0;
    end else begin
      in_flight <= fifo_rd_en;
      if (fifo_rd_en) rd_issued <= rd_issued + CW'(1);
      if (in_flight) begin
        acc       <= acc_cap;
        lanes_cap <= lanes_cap + CW'(1);
      end

      case (state)
        FILL: begin
          if (flush_go) begin
            rd_issued <= '0;
            lanes_cap <= '0;
          end else if (fifo_rd_en && (rd_issued == LAST)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (in_flight) begin
            if (slot_free) begin
              rd_issued <= '0;
              lanes_cap <= '0;
              state     <= FILL;
            end else begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (slot_free) begin
            rd_issued <= '0;
            lanes_cap <= '0;
            state     <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  pack_out_slot #(
    .WIDTH (DATA_WIDTH * PACK_RATIO)
`ifdef PACKER_FLUSH_EN
    , .KEEP_W (PACK_RATIO)
`endif
  ) u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (load_data),
`ifdef PACKER_FLUSH_EN
    .load_keep (load_keep),
    .m_keep    (m_keep),
`endif
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data)
  );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a behavioural FIFO source.
module tb_fifo_rd_packer;
  import fifo_rd_packer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_rd_en;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
`ifdef PACKER_FLUSH_EN
  logic        flush;
  logic [3:0]  m_keep;
`endif

  fifo_rd_packer #(.DATA_WIDTH(8), .PACK_RATIO(4)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
`ifdef PACKER_FLUSH_EN
    .flush      (flush),
    .m_keep     (m_keep),
`endif
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[5];
  logic [7:0]  q[$];
  logic [31:0] got_q[$];
  int          got_c[$];
`ifdef PACKER_FLUSH_EN
  logic [3:0]  got_k[$];
`endif
  int n_chk = 0, n_pass = 0;
  int cyc_n = 0, n_reads, n_valid, first_rd, first_v, rd_when_empty = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [31:0] got(input int i);
    return (i < got_q.size()) ? got_q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic clear_stats();
    got_q.delete();
    got_c.delete();
`ifdef PACKER_FLUSH_EN
    got_k.delete();
`endif
    n_reads = 0; n_valid = 0; first_rd = -1; first_v = -1;
  endtask

  // One clock: sample just before the edge, update FIFO model after it.
  task automatic cyc();
    logic rd;
    #1;
    rd = fifo_rd_en;
    if (rd && fifo_empty) rd_when_empty++;
    if (rd) begin
      n_reads++;
      if (first_rd < 0) first_rd = cyc_n;
    end
    if (m_valid) begin
      n_valid++;
      if (first_v < 0) first_v = cyc_n;
    end
    if (m_valid && m_ready) begin
      got_q.push_back(m_data);
      got_c.push_back(cyc_n);
`ifdef PACKER_FLUSH_EN
      got_k.push_back(m_keep);
`endif
    end
    @(posedge clk);
    #1;
    if (rd && q.size() > 0) fifo_data = q.pop_front();
    fifo_empty = (q.size() == 0);
    cyc_n++;
  endtask

  task automatic run_word(input logic [7:0] b0, b1, b2, b3, input logic [31:0] exp, input string nm);
    clear_stats();
    m_ready = 1'b1;
    push(b0); push(b1); push(b2); push(b3);
    for (int k = 0; k < 20 && got_q.size() == 0; k++) cyc();
    repeat (3) cyc();
    chk({nm, " data"}, 64'(got(0)), 64'(exp));
    chk({nm, " reads"}, 64'(n_reads), 64'd4);
    chk({nm, " latency"}, 64'(first_v - first_rd), 64'd5);
    chk({nm, " valid_cycles"}, 64'(n_valid), 64'd1);
`ifdef PACKER_FLUSH_EN
    chk({nm, " keep"}, 64'((got_k.size() > 0) ? got_k[0] : 4'h0), 64'hF);
`endif
  endtask

  initial begin
    int unstable;
    vecs[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 32'h4433_2211};
    vecs[1] = '{8'h00, 8'h01, 8'h02, 8'h03, 32'h0302_0100};
    vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 32'h00FF_00FF};
    vecs[3] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hEFBE_ADDE};
    vecs[4] = '{8'h80, 8'h01, 8'h7F, 8'hFE, 32'hFE7F_0180};

    rst_n = 1'b0; fifo_empty = 1'b1; fifo_data = 8'h00; m_ready = 1'b0;
`ifdef PACKER_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset m_valid", 64'(m_valid), 64'd0);
    chk("reset m_data", 64'(m_data), 64'd0);
    chk("reset rd_en", 64'(fifo_rd_en), 64'd0);

    for (int v = 0; v < 5; v++)
      run_word(vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3, vecs[v].exp, $sformatf("vec%0d", v));

    // Back-to-back streaming of four words.
    clear_stats();
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(i));
    for (int k = 0; k < 40 && got_q.size() < 4; k++) cyc();
    chk("stream w0", 64'(got(0)), 64'h0302_0100);
    chk("stream w1", 64'(got(1)), 64'h0706_0504);
    chk("stream w2", 64'(got(2)), 64'h0B0A_0908);
    chk("stream w3", 64'(got(3)), 64'h0F0E_0D0C);
    for (int i = 0; i < 3; i++)
      chk($sformatf("stream gap%0d", i),
          64'((got_c.size() == 4) ? got_c[i+1] - got_c[i] : 0), 64'd5);

    // Backpressure: slot and accumulator fill, FIFO keeps the rest.
    repeat (3) cyc();
    clear_stats();
    m_ready = 1'b0;
    unstable = 0;
    for (int i = 0; i < 12; i++) push(8'h20 + 8'(i));
    repeat (20) begin
      cyc();
      if (m_valid && m_data !== 32'h2322_2120) unstable++;
    end
    chk("bp reads", 64'(n_reads), 64'd8);
    chk("bp fifo_count", 64'(q.size()), 64'd4);
    chk("bp m_valid", 64'(m_valid), 64'd1);
    chk("bp m_data", 64'(m_data), 64'h2322_2120);
    chk("bp stable", 64'(unstable), 64'd0);
    chk("bp state", 64'(u_dut.state), 64'(HOLD));
    m_ready = 1'b1;
    for (int k = 0; k < 40 && got_q.size() < 3; k++) cyc();
    chk("bp w0", 64'(got(0)), 64'h2322_2120);
    chk("bp w1", 64'(got(1)), 64'h2726_2524);
    chk("bp w2", 64'(got(2)), 64'h2B2A_2928);
    repeat (3) cyc();

    // Reset asserted while the last lane is in flight.
    clear_stats();
    push(8'h01); push(8'h02); push(8'h03);
    repeat (6) cyc();
    push(8'h04);
    cyc();
    chk("rst pre state", 64'(u_dut.state), 64'(DRAIN));
    rst_n = 1'b0;
    push(8'h99);
    #1;
    chk("rst rd_en", 64'(fifo_rd_en), 64'd0);
    chk("rst m_valid", 64'(m_valid), 64'd0);
    chk("rst rd_issued", 64'(u_dut.rd_issued), 64'd0);
    chk("rst lanes_cap", 64'(u_dut.lanes_cap), 64'd0);
    q.delete();
    fifo_empty = 1'b1;
    repeat (2) cyc();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_word(8'hA1, 8'hB2, 8'hC3, 8'hD4, 32'hD4C3_B2A1, "post_rst");

    // Idle FIFO: no read requests.
    clear_stats();
    rd_when_empty = 0;
    repeat (50) cyc();
    chk("idle reads", 64'(n_reads), 64'd0);
    chk("idle rd_when_empty", 64'(rd_when_empty), 64'd0);
    chk("idle m_valid", 64'(n_valid), 64'd0);

`ifdef PACKER_FLUSH_EN
    // Flush with nothing captured is ignored.
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("flush empty ignored", 64'(m_valid), 64'd0);
    clear_stats();
    push(8'hAA); push(8'hBB);
    repeat (4) cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("flush m_valid", 64'(m_valid), 64'd1);
    chk("flush m_data", 64'(m_data), 64'h0000_BBAA);
    chk("flush m_keep", 64'(m_keep), 64'h3);
    chk("flush lanes_cap", 64'(u_dut.lanes_cap), 64'd0);
    repeat (2) cyc();
    run_word(8'h01, 8'h23, 8'h45, 8'h67, 32'h6745_2301, "post_flush");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Downstream consumer of the 8-bit counter-based sync FIFO. It drains the FIFO through its rd_en/empty interface and packs PACK_RATIO consecutive FIFO words into one wide word. The wide word is presented on a valid/ready master port and feeds the wide datapath stages.

## Interface
- DATA_WIDTH, 8, width of one FIFO word (lane)
- PACK_RATIO, 4, lanes per output word; integer ≥ 2
- clk  in  1  single clock; all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- fifo_empty  in  1  FIFO empty flag
- fifo_data  in  DATA_WIDTH  FIFO read data; valid the cycle after an accepted fifo_rd_en
- fifo_rd_en  out  1  FIFO read request; combinational from registered state; only ever high when fifo_empty==0
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_WIDTH*PACK_RATIO  packed word; lane 0 = first FIFO word read, in the LSBs

## Operation
- Registers:
  - issue counter rd_issued (0..PACK_RATIO)
  - capture counter lanes_cap (0..PACK_RATIO)
  - in-flight flag
  - accumulator of PACK_RATIO lanes
  - output slot: m_data, m_valid
- fifo_rd_en = !fifo_empty && rd_issued < PACK_RATIO && state != HOLD.
- An accepted read sets in-flight. Next edge: fifo_data is written into accumulator lane lanes_cap, and lanes_cap increments.
- States:
  - FILL: issuing reads. Go to DRAIN when rd_issued reaches PACK_RATIO.
  - DRAIN: last lane in flight. When it is captured:
    - if the output slot is free (m_valid==0, or m_valid && m_ready), load m_data with the accumulator including the captured lane, set m_valid, clear both counters, go to FILL;
    - otherwise go to HOLD.
  - HOLD: accumulator full, slot busy. Load the slot on m_valid && m_ready, clear counters, go to FILL.
- Output handshake:
  - m_valid && m_ready pops the slot.
  - m_data and m_valid stay stable while m_valid && !m_ready.
  - A pop and a load in the same edge leave m_valid high with the new data.
- Counters never exceed PACK_RATIO; they use $clog2(PACK_RATIO)+1 bits.
- An idle FIFO mid-word stalls filling indefinitely. No partial word is emitted unless the flush feature is compiled in.
- Reset, asynchronous:
  - state=FILL; counters, in-flight flag, accumulator, m_data, m_valid all 0.
  - fifo_rd_en is 0 while rst_n is low.
  - Deasserting reset mid-word discards all partial lanes.

## Timing
- Reads issued in cycles 0..3 (PACK_RATIO=4) give fifo_data in cycles 1..4. m_valid is first high in cycle 5.
- Sustained throughput: one output word per PACK_RATIO+1 cycles. There is one issue bubble per word, in DRAIN.
- With m_ready held low, at most one word in the slot plus one in the accumulator. Reads then stop, and the FIFO absorbs the backpressure.

## Configuration
- PACKER_FLUSH_EN defined:
  - Adds input flush (1 bit) and output m_keep (PACK_RATIO bits, lane-valid mask).
  - Condition: flush high in FILL, lanes_cap > 0, nothing in flight, output slot free.
  - Response: the partial word loads into the slot, with unfilled lanes zero and m_keep bits set for captured lanes only. Counters then clear.
  - Flush with lanes_cap==0 is ignored. Flush in DRAIN or HOLD is ignored.
  - Full words carry m_keep = all ones.
  - Flush blocks fifo_rd_en in the cycle it is honoured.
- PACKER_FLUSH_EN undefined: no flush or m_keep ports; only full words are emitted.

## Structure
- Package fifo_rd_packer_pkg holds:
  - the state typedef (FILL, DRAIN, HOLD);
  - default DATA_WIDTH and PACK_RATIO constants;
  - the function deriving the counter width.
- One sub-module is natural: pack_out_slot, the valid/ready output holding register with load/pop logic.

## Test plan
- Reset, then write 0x11,0x22,0x33,0x44 to the FIFO with m_ready=1:
  - fifo_rd_en high in exactly 4 cycles;
  - m_data=0x44332211 with m_valid for one cycle, 5 cycles after the first read.
- Stream 16 bytes 0x00..0x0F, m_ready=1: expect 4 words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, each 5 cycles apart.
- Hold m_ready=0 while streaming 12 bytes:
  - first word held stable; second word in HOLD;
  - fifo_rd_en low after 8 reads; FIFO count stays 4.
  - On raising m_ready, all 3 words arrive in order.
- Write 3 bytes, then pulse rst_n low mid-DRAIN: m_valid=0, counters 0; the next 4 bytes form a clean word.
- Empty FIFO for 50 cycles: fifo_rd_en never asserts while fifo_empty=1.
- With PACKER_FLUSH_EN, write 0xAA,0xBB then pulse flush: m_data=0x0000BBAA, m_keep=4'b0011.
